// File: rtl/cfg_space_arbiter_pkg.sv
// rtl/cfg_space_arbiter_pkg.sv - shared state encoding and default sizes for the config-space arbiter
package cfg_space_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int DEF_DATA_WD     = 32;
    localparam int DEF_ADDR_WD     = 16;

endpackage

// File: rtl/cfg_space_arbiter_if.sv
// rtl/cfg_space_arbiter_if.sv - requester and config-space bundle seen by the arbiter
interface cfg_space_arbiter_if
    import cfg_space_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int ADDR_WD = DEF_ADDR_WD
) ();
    logic [NUM_REQ-1:0]         APB_Request;
    logic [NUM_REQ*ADDR_WD-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WD-1:0] REQ_DATA;
    logic [NUM_REQ*4-1:0]       REQ_STRB;
    logic [NUM_REQ-1:0]         REQ_WRITE;
    logic [NUM_REQ-1:0]         APB_Grant;

    logic                       CFG_Valid;
    logic [ADDR_WD-1:0]         CFG_ADDR;
    logic [DATA_WD-1:0]         CFG_DATA;
    logic [3:0]                 CFG_STRB;
    logic                       CFG_WRITE;
    logic                       CFG_ACK;
    logic                       CFG_RVALID;
    logic [DATA_WD-1:0]         CFG_RDATA;

    logic [NUM_REQ-1:0]         ConfigSp_ACKAPB;
    logic [NUM_REQ-1:0]         ConfigSp_APBValid;
    logic [DATA_WD-1:0]         ConfigSp_DATA;
    logic [NUM_REQ-1:0]         Timeout_ER;
    logic                       Arb_Busy;

    modport slave (
        input  APB_Request, REQ_ADDR, REQ_DATA, REQ_STRB, REQ_WRITE,
        input  CFG_ACK, CFG_RVALID, CFG_RDATA,
        output APB_Grant, CFG_Valid, CFG_ADDR, CFG_DATA, CFG_STRB, CFG_WRITE,
        output ConfigSp_ACKAPB, ConfigSp_APBValid, ConfigSp_DATA, Timeout_ER, Arb_Busy
    );

    modport master (
        output APB_Request, REQ_ADDR, REQ_DATA, REQ_STRB, REQ_WRITE,
        output CFG_ACK, CFG_RVALID, CFG_RDATA,
        input  APB_Grant, CFG_Valid, CFG_ADDR, CFG_DATA, CFG_STRB, CFG_WRITE,
        input  ConfigSp_ACKAPB, ConfigSp_APBValid, ConfigSp_DATA, Timeout_ER, Arb_Busy
    );
endinterface

// File: rtl/cfg_space_arbiter_rr_priority_sel.sv
// rtl/cfg_space_arbiter_rr_priority_sel.sv - combinational round-robin pick starting after the last winner
module rr_priority_sel
    import cfg_space_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_WD  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_WD-1:0]  last_winner,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_WD-1:0]  sel_idx
);
    logic found;

    // Offset k=1 is the highest priority slot, k=NUM_REQ is the last winner itself.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((int'(last_winner) + k) % NUM_REQ) == i)) begin
                    found   = 1'b1;
                    sel[i]  = 1'b1;
                    sel_idx = IDX_WD'(i);
                end
            end
        end
    end
endmodule

// File: rtl/cfg_space_arbiter.sv
// rtl/cfg_space_arbiter.sv - shares one configuration space between NUM_REQ requesters with timeout abort
module cfg_space_arbiter
    import cfg_space_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_WD     = DEF_DATA_WD,
    parameter int ADDR_WD     = DEF_ADDR_WD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic                PCLK,
    input logic                PRESET,
    cfg_space_arbiter_if.slave bus
);
    localparam int IDX_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT_CYC - 1);

    arb_state_t state, state_nxt;

    logic [NUM_REQ-1:0] pick_oh, win_oh;
    logic [IDX_WD-1:0]  pick_idx, win_idx, last_idx;
    logic [CNT_WD-1:0]  cnt;
    logic [ADDR_WD-1:0] pick_addr, cap_addr;
    logic [DATA_WD-1:0] pick_data, cap_data, rdata_q;
    logic [3:0]         pick_strb, cap_strb;
    logic               pick_write, cap_write;
    logic               acked, rd_hit, timed_out;
    logic               ack_now, tmo_now, rd_now;

    rr_priority_sel #(.NUM_REQ(NUM_REQ), .IDX_WD(IDX_WD)) u_sel (
        .req         (bus.APB_Request),
        .last_winner (last_idx),
        .sel         (pick_oh),
        .sel_idx     (pick_idx)
    );

    always_comb begin
        pick_addr  = '0;
        pick_data  = '0;
        pick_strb  = '0;
        pick_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_addr  = bus.REQ_ADDR[i*ADDR_WD +: ADDR_WD];
                pick_data  = bus.REQ_DATA[i*DATA_WD +: DATA_WD];
                pick_strb  = bus.REQ_STRB[i*4 +: 4];
                pick_write = bus.REQ_WRITE[i];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ACK has priority over a timeout landing in the same cycle.
    always_comb begin
        ack_now   = (state == ST_BUSY) && bus.CFG_ACK;
        tmo_now   = (state == ST_BUSY) && !bus.CFG_ACK && (cnt == CNT_LAST);
        rd_now    = ack_now && !cap_write && bus.CFG_RVALID;
        state_nxt = state;
        case (state)
            ST_IDLE: if (|bus.APB_Request) state_nxt = ST_BUSY;
            ST_BUSY: if (ack_now || tmo_now) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        bus.APB_Grant         = (state == ST_BUSY) ? win_oh : '0;
        bus.CFG_Valid         = (state == ST_BUSY);
        bus.CFG_ADDR          = cap_addr;
        bus.CFG_DATA          = cap_data;
        bus.CFG_STRB          = cap_strb;
        bus.CFG_WRITE         = cap_write;
        bus.ConfigSp_ACKAPB   = (state == ST_DONE && acked)     ? win_oh : '0;
        bus.ConfigSp_APBValid = (state == ST_DONE && rd_hit)    ? win_oh : '0;
        bus.Timeout_ER        = (state == ST_DONE && timed_out) ? win_oh : '0;
        bus.ConfigSp_DATA     = rdata_q;
        bus.Arb_Busy          = (state != ST_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            win_oh    <= '0;
            win_idx   <= '0;
            last_idx  <= IDX_WD'(NUM_REQ - 1);
            cnt       <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_strb  <= '0;
            cap_write <= 1'b0;
            acked     <= 1'b0;
            rd_hit    <= 1'b0;
            timed_out <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.APB_Request) begin
                        win_oh    <= pick_oh;
                        win_idx   <= pick_idx;
                        cap_addr  <= pick_addr;
                        cap_data  <= pick_data;
                        cap_strb  <= pick_strb;
                        cap_write <= pick_write;
                    end
                end
                ST_BUSY: begin
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    acked     <= ack_now;
                    rd_hit    <= rd_now;
                    timed_out <= tmo_now;
                    if (rd_now) rdata_q <= bus.CFG_RDATA;
                end
                ST_DONE: begin
                    last_idx  <= win_idx;
                    cnt       <= '0;
                    acked     <= 1'b0;
                    rd_hit    <= 1'b0;
                    timed_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_space_arbiter.sv
// tb/tb_cfg_space_arbiter.sv - directed and randomized checks of cfg_space_arbiter against a transaction model
module tb_cfg_space_arbiter;
    localparam int NR   = 4;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int TCYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    cfg_space_arbiter_if #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW)) bus ();

    cfg_space_arbiter #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW), .TIMEOUT_CYC(TCYC)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d required 0", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] oh(input bit on, input int who);
        logic [NR-1:0] v;
        v = '0;
        if (on) v[who] = 1'b1;
        return v;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: one outstanding access, its age, and a pending completion report.
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    int            m_win    = 0;
    int            m_last   = NR - 1;
    int            m_age    = 0;
    int            m_kind   = 0;
    int            m_pick   = -1;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_data   = '0;
    logic [DW-1:0] m_rdata  = '0;
    logic [3:0]    m_strb   = '0;
    logic          m_write  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_win = 0; m_last = NR - 1; m_age = 0; m_kind = 0;
            m_addr = '0; m_data = '0; m_rdata = '0; m_strb = '0; m_write = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_kind = 0;
            m_last = m_win;
        end else if (m_active) begin
            m_age++;
            if (bus.CFG_ACK) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_kind   = (!m_write && bus.CFG_RVALID) ? 2 : 1;
                if (m_kind == 2) m_rdata = bus.CFG_RDATA;
            end else if (m_age == TCYC) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_kind   = 3;
            end
        end else if (bus.APB_Request != '0) begin
            m_pick = -1;
            for (int k = 1; k <= NR; k++)
                if (m_pick < 0 && bus.APB_Request[(m_last + k) % NR]) m_pick = (m_last + k) % NR;
            m_win    = m_pick;
            m_active = 1'b1;
            m_age    = 0;
            m_addr   = bus.REQ_ADDR[m_pick*AW +: AW];
            m_data   = bus.REQ_DATA[m_pick*DW +: DW];
            m_strb   = bus.REQ_STRB[m_pick*4 +: 4];
            m_write  = bus.REQ_WRITE[m_pick];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",     64'(bus.APB_Grant),         64'(oh(m_active, m_win)));
            chk("cfg_valid", 64'(bus.CFG_Valid),         64'(m_active));
            if (m_active) begin
                chk("cfg_addr",  64'(bus.CFG_ADDR),  64'(m_addr));
                chk("cfg_data",  64'(bus.CFG_DATA),  64'(m_data));
                chk("cfg_strb",  64'(bus.CFG_STRB),  64'(m_strb));
                chk("cfg_write", 64'(bus.CFG_WRITE), 64'(m_write));
            end
            chk("ackapb",    64'(bus.ConfigSp_ACKAPB),   64'(oh(m_done && (m_kind == 1 || m_kind == 2), m_win)));
            chk("apbvalid",  64'(bus.ConfigSp_APBValid), 64'(oh(m_done && m_kind == 2, m_win)));
            chk("timeout",   64'(bus.Timeout_ER),        64'(oh(m_done && m_kind == 3, m_win)));
            chk("sp_data",   64'(bus.ConfigSp_DATA),     64'(m_rdata));
            chk("busy",      64'(bus.Arb_Busy),          64'(m_active || m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        bus.REQ_ADDR[i*AW +: AW] = a;
        bus.REQ_DATA[i*DW +: DW] = d;
        bus.REQ_STRB[i*4 +: 4]   = 4'hF;
        bus.REQ_WRITE[i]         = w;
    endtask

    int order[$];
    int gcyc[$];
    logic [NR-1:0] prev_g;
    int to_off, to_who, ack_seen;

    initial begin
        bus.APB_Request = '0; bus.REQ_ADDR = '0; bus.REQ_DATA = '0; bus.REQ_STRB = '0; bus.REQ_WRITE = '0;
        bus.CFG_ACK = 1'b0; bus.CFG_RVALID = 1'b0; bus.CFG_RDATA = '0;
        rst = 1'b1;
        tick;
        chk_en = 1'b1;
        tick;
        look;
        chk("rst_grant", 64'(bus.APB_Grant), 64'(0));
        chk("rst_busy",  64'(bus.Arb_Busy), 64'(0));
        chk("rst_data",  64'(bus.ConfigSp_DATA), 64'(0));
        rst = 1'b0;

        // single write from requester 2, ACK two cycles after grant
        set_req(2, 16'd12, 32'd152, 1'b1);
        bus.APB_Request = 4'b0100;
        tick; look;
        chk("s1_grant", 64'(bus.APB_Grant), 64'(4'b0100));
        chk("s1_addr",  64'(bus.CFG_ADDR), 64'(12));
        chk("s1_data",  64'(bus.CFG_DATA), 64'(152));
        bus.APB_Request = '0;
        tick; tick;
        bus.CFG_ACK = 1'b1;
        tick; look;
        chk("s1_ackapb", 64'(bus.ConfigSp_ACKAPB), 64'(4'b0100));
        bus.CFG_ACK = 1'b0;
        tick; look;
        chk("s1_ackapb_off", 64'(bus.ConfigSp_ACKAPB), 64'(0));

        // all four requesting continuously after reset
        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(100 + i), DW'(200 + i), 1'b1);
        bus.APB_Request = 4'hF;
        bus.CFG_ACK = 1'b1;
        prev_g = '0;
        repeat (16) begin
            tick; look;
            if (bus.APB_Grant != '0 && prev_g == '0) begin
                order.push_back(oh2idx(bus.APB_Grant));
                gcyc.push_back(cyc);
            end
            prev_g = bus.APB_Grant;
        end
        chk("rr_count", 64'(order.size() >= 5), 64'(1));
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) chk("rr_order", 64'(order[k]), 64'(k % NR));
            if (k > 0 && k < gcyc.size()) chk("rr_gap", 64'((gcyc[k] - gcyc[k-1]) >= 3), 64'(1));
        end
        bus.APB_Request = '0;
        tick; tick; tick;
        bus.CFG_ACK = 1'b0;

        // read by requester 1 returning 150
        set_req(1, 16'd40, 32'd0, 1'b0);
        bus.APB_Request = 4'b0010;
        tick; look;
        chk("s3_grant", 64'(bus.APB_Grant), 64'(4'b0010));
        bus.APB_Request = '0;
        bus.CFG_ACK = 1'b1; bus.CFG_RVALID = 1'b1; bus.CFG_RDATA = 32'd150;
        tick; look;
        chk("s3_sp_data",  64'(bus.ConfigSp_DATA), 64'(150));
        chk("s3_apbvalid", 64'(bus.ConfigSp_APBValid), 64'(4'b0010));
        bus.CFG_ACK = 1'b0; bus.CFG_RVALID = 1'b0; bus.CFG_RDATA = '0;
        tick; look;
        chk("s3_apbvalid_off", 64'(bus.ConfigSp_APBValid), 64'(0));
        chk("s3_sp_hold",      64'(bus.ConfigSp_DATA), 64'(150));

        // no ACK: timeout pulse 9 cycles after the request cycle (8 after grant)
        bus.APB_Request = 4'b0001;
        to_off = -1; to_who = 0; ack_seen = 0;
        for (int off = 1; off <= 14; off++) begin
            tick; look;
            if (off == 1) chk("s4_grant", 64'(bus.APB_Grant), 64'(4'b0001));
            bus.APB_Request = '0;
            if (bus.Timeout_ER != '0 && to_off < 0) begin to_off = off; to_who = int'(bus.Timeout_ER); end
            if (bus.ConfigSp_ACKAPB != '0) ack_seen++;
        end
        chk("s4_timeout_offset", 64'(to_off), 64'(9));
        chk("s4_timeout_who",    64'(to_who), 64'(1));
        chk("s4_no_ackapb",      64'(ack_seen), 64'(0));

        // ACK on the 8th BUSY cycle beats the timeout
        bus.APB_Request = 4'b0100;
        tick; look;
        chk("s5_grant", 64'(bus.APB_Grant), 64'(4'b0100));
        bus.APB_Request = '0;
        repeat (7) tick;
        bus.CFG_ACK = 1'b1;
        tick; look;
        chk("s5_ackapb",  64'(bus.ConfigSp_ACKAPB), 64'(4'b0100));
        chk("s5_timeout", 64'(bus.Timeout_ER), 64'(0));
        bus.CFG_ACK = 1'b0;
        tick;

        // reset on BUSY cycle 3 aborts silently; requester 0 wins next
        bus.APB_Request = 4'hF;
        tick; look;
        chk("s6_grant", 64'(bus.APB_Grant), 64'(4'b1000));
        tick; tick;
        rst = 1'b1;
        tick; look;
        chk("s6_rst_grant",   64'(bus.APB_Grant), 64'(0));
        chk("s6_rst_valid",   64'(bus.CFG_Valid), 64'(0));
        chk("s6_rst_addr",    64'(bus.CFG_ADDR), 64'(0));
        chk("s6_rst_data",    64'(bus.CFG_DATA), 64'(0));
        chk("s6_rst_pulses",  64'({bus.ConfigSp_ACKAPB, bus.ConfigSp_APBValid, bus.Timeout_ER}), 64'(0));
        chk("s6_rst_sp_data", 64'(bus.ConfigSp_DATA), 64'(0));
        chk("s6_rst_busy",    64'(bus.Arb_Busy), 64'(0));
        rst = 1'b0;
        tick; look;
        chk("s6_next_grant", 64'(bus.APB_Grant), 64'(4'b0001));
        bus.APB_Request = '0;
        bus.CFG_ACK = 1'b1;
        tick; tick;
        bus.CFG_ACK = 1'b0;

        // randomized traffic against the model
        repeat (600) begin
            rst = ($urandom_range(0, 127) == 0);
            bus.APB_Request = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                bus.REQ_ADDR[i*AW +: AW] = AW'($urandom);
                bus.REQ_DATA[i*DW +: DW] = $urandom;
                bus.REQ_STRB[i*4 +: 4]   = 4'($urandom_range(0, 15));
                bus.REQ_WRITE[i]         = 1'($urandom_range(0, 1));
            end
            bus.CFG_ACK    = ($urandom_range(0, 3) == 0);
            bus.CFG_RVALID = 1'($urandom_range(0, 1));
            bus.CFG_RDATA  = $urandom;
            tick;
        end
        rst = 1'b0;
        tick; look;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
